// File: rtl/ram_stream_loader_pkg.sv
// Shared definitions for the RAM stream loader: FSM state encoding and
// framing constants.
package ram_stream_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 2;
  localparam int RAM4K_ADDR_W   = 12;

endpackage

// File: rtl/ram_stream_loader_byte_pair_assembler.sv
// Pairs consecutive accepted bytes into a big-endian word; word_valid is
// asserted combinationally on the cycle the second byte is accepted.
module ram_stream_loader_byte_pair_assembler
  import ram_stream_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [7:0]                  byte_in,
  input  logic                        fire,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic                        word_valid
);

  logic [7:0] hi_reg;
  logic       phase_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hi_reg    <= 8'h00;
      phase_reg <= 1'b0;
    end else if (fire) begin
      if (!phase_reg) begin
        hi_reg <= byte_in;
      end
      phase_reg <= ~phase_reg;
    end
  end

  // The low byte is used straight from the stream so the FSM can act on the
  // complete word at the same edge that accepts it.
  assign word       = {hi_reg, byte_in};
  assign word_valid = fire && phase_reg;

endmodule

// File: rtl/ram_stream_loader.sv
// Loads a length-prefixed big-endian word stream into RAM from address 0,
// passing the CPU write port through whenever the loader is idle.
module ram_stream_loader
  import ram_stream_loader_pkg::*;
#(
  parameter int ADDR_W = RAM4K_ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_load,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int         CNT_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t             state_reg;
  logic [15:0]        len_reg;
  logic [DATA_W-1:0]  word_reg;
  logic [CNT_W-1:0]   addr_cnt_reg;
  logic               done_reg;
  logic               error_reg;

  logic               byte_fire;
  logic               start_accept;
  logic [15:0]        asm_word;
  logic               asm_valid;
  logic [16:0]        addr_next;

  assign byte_ready   = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                        (state_reg == DATA_HI) || (state_reg == DATA_LO);
  assign byte_fire    = byte_valid && byte_ready;
  assign start_accept = start && (state_reg == IDLE);
  assign addr_next    = 17'(addr_cnt_reg) + 17'd1;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign error        = error_reg;

  ram_stream_loader_byte_pair_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .byte_in    (byte_in),
    .fire       (byte_fire),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      len_reg      <= 16'h0000;
      word_reg     <= '0;
      addr_cnt_reg <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            error_reg <= 1'b0;
            state_reg <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (byte_fire) state_reg <= LEN_LO;
        end
        LEN_LO: begin
          if (asm_valid) begin
            len_reg <= asm_word;
            if (asm_word == 16'h0000) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else if ({1'b0, asm_word} > DEPTH) begin
              error_reg <= 1'b1;
              state_reg <= IDLE;
            end else begin
              addr_cnt_reg <= '0;
              state_reg    <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (byte_fire) state_reg <= DATA_LO;
        end
        DATA_LO: begin
          if (asm_valid) begin
            word_reg  <= asm_word;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          // Counter is one bit wider than the address so N = depth compares cleanly.
          if (addr_next == {1'b0, len_reg}) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            addr_cnt_reg <= addr_cnt_reg + 1'b1;
            state_reg    <= DATA_HI;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_in      = cpu_in;
    mem_load    = cpu_load;
    mem_address = cpu_address;
    if (state_reg != IDLE) begin
      mem_in      = word_reg;
      mem_load    = (state_reg == WRITE);
      mem_address = addr_cnt_reg[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader: passthrough, normal load, length
// overflow, zero length, backpressure with CPU contention, mid-load reset.
module tb_ram_stream_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic [11:0] cpu_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [11:0] mem_address;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp;
  int n_err;

  ram_stream_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .cpu_in      (cpu_in),
    .cpu_load    (cpu_load),
    .cpu_address (cpu_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model plus a log of writes made while the loader owns the port.
  logic [15:0] ram [0:4095];
  logic [11:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          cyc;
  int          done_cnt;

  initial begin
    cyc      = 0;
    done_cnt = 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_load) ram[mem_address] <= mem_in;
    if (busy && mem_load) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_in);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !byte_ready; i++) tick();
    chk("ready_wait", {31'd0, byte_ready}, 32'd1);
    tick();
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      byte_valid = 1'b0;
      byte_in    = 8'hEE;
      tick();
    end
    send_byte(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int base;
  int dbase;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    start       = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    cpu_in      = 16'h0000;
    cpu_load    = 1'b0;
    cpu_address = 12'h000;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    tick();

    // Idle passthrough
    cpu_load = 1'b1; cpu_address = 12'h123; cpu_in = 16'hBEEF;
    #1;
    chk("pt_load", {31'd0, mem_load}, 32'd1);
    chk("pt_addr", {20'd0, mem_address}, 32'h123);
    chk("pt_data", {16'd0, mem_in}, 32'hBEEF);
    chk("pt_busy", {31'd0, busy}, 32'd0);
    chk("pt_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    cpu_load = 1'b0;

    // N=3 load, byte_valid held high
    base = wr_addr.size();
    pulse_start();
    chk("n3_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00); send_byte(8'h01);
    byte_valid = 1'b0;
    chk("n3_last_load", {31'd0, mem_load}, 32'd1);
    chk("n3_last_addr", {20'd0, mem_address}, 32'd2);
    tick();
    chk("n3_done", {31'd0, done}, 32'd1);
    chk("n3_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("n3_done_drop", {31'd0, done}, 32'd0);
    chk("n3_nwr", wr_addr.size() - base, 32'd3);
    if (wr_addr.size() >= base + 3) begin
      chk("n3_a0", {20'd0, wr_addr[base]},   32'd0);
      chk("n3_d0", {16'd0, wr_data[base]},   32'h1234);
      chk("n3_a1", {20'd0, wr_addr[base+1]}, 32'd1);
      chk("n3_d1", {16'd0, wr_data[base+1]}, 32'hABCD);
      chk("n3_a2", {20'd0, wr_addr[base+2]}, 32'd2);
      chk("n3_d2", {16'd0, wr_data[base+2]}, 32'h0001);
      chk("n3_gap01", wr_cyc[base+1] - wr_cyc[base],   32'd3);
      chk("n3_gap12", wr_cyc[base+2] - wr_cyc[base+1], 32'd3);
    end
    chk("n3_done_cnt", done_cnt, 32'd1);

    // Length overflow N=4097
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h10); send_byte(8'h01);
    byte_valid = 1'b0;
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_done", {31'd0, done}, 32'd0);
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ovf_sticky", {31'd0, error}, 32'd1);
    chk("ovf_nwr", wr_addr.size() - base, 32'd0);

    // Accepted start clears error; then zero-length header
    pulse_start();
    chk("clr_error", {31'd0, error}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_nwr", wr_addr.size() - base, 32'd0);
    tick();
    chk("zero_done_cnt", done_cnt, 32'd2);

    // Backpressure with CPU contention, N=2
    base = wr_addr.size();
    cpu_load = 1'b1; cpu_address = 12'h005; cpu_in = 16'hDEAD;
    pulse_start();
    chk("bp_cpu_blocked", {31'd0, mem_load}, 32'd0);
    send_byte_gap(8'h00); send_byte_gap(8'h02);
    send_byte_gap(8'h5A); send_byte_gap(8'hA5);
    send_byte_gap(8'h0F); send_byte_gap(8'hF0);
    byte_valid = 1'b0;
    tick();
    cpu_load = 1'b0;
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_nwr", wr_addr.size() - base, 32'd2);
    if (wr_addr.size() >= base + 2) begin
      chk("bp_a0", {20'd0, wr_addr[base]},   32'd0);
      chk("bp_d0", {16'd0, wr_data[base]},   32'h5AA5);
      chk("bp_a1", {20'd0, wr_addr[base+1]}, 32'd1);
      chk("bp_d1", {16'd0, wr_data[base+1]}, 32'h0FF0);
    end
    tick();
    chk("bp_ram0", {16'd0, ram[0]}, 32'h5AA5);
    chk("bp_ram1", {16'd0, ram[1]}, 32'h0FF0);

    // Reset in DATA_LO after two words
    base  = wr_addr.size();
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h22);
    send_byte(8'h33);
    byte_valid = 1'b0;
    chk("mr_ready_lo", {31'd0, byte_ready}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, byte_ready}, 32'd0);
    cpu_load = 1'b1; cpu_address = 12'h7FF; cpu_in = 16'h4242;
    #1;
    chk("mr_pt_load", {31'd0, mem_load}, 32'd1);
    chk("mr_pt_addr", {20'd0, mem_address}, 32'h7FF);
    chk("mr_pt_data", {16'd0, mem_in}, 32'h4242);
    tick();
    cpu_load = 1'b0;
    tick();
    tick();
    chk("mr_nwr", wr_addr.size() - base, 32'd2);
    chk("mr_ram0", {16'd0, ram[0]}, 32'h1111);
    chk("mr_ram1", {16'd0, ram[1]}, 32'h2222);
    chk("mr_no_done", done_cnt - dbase, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
